// File: rtl/cycle_sequencer_if.sv
// Nibble-bus and status bundle between the cycle sequencer and the decoder.
// The master side is the sequencer; the slave side is the decoder/ROM.
interface cycle_sequencer_if;
  logic [3:0] rom_data;
  logic       stop_req;
  logic [2:0] cycle;
  logic       sync;
  logic [3:0] opr;
  logic [3:0] opa;
  logic [7:0] op2;
  logic       word2;
  logic       pc_inc;
  logic       exec_done;
  logic       stop_ack;

  modport master (
    input  rom_data,
    input  stop_req,
    output cycle,
    output sync,
    output opr,
    output opa,
    output op2,
    output word2,
    output pc_inc,
    output exec_done,
    output stop_ack
  );

  modport slave (
    output rom_data,
    output stop_req,
    input  cycle,
    input  sync,
    input  opr,
    input  opa,
    input  op2,
    input  word2,
    input  pc_inc,
    input  exec_done,
    input  stop_ack
  );
endinterface

// File: rtl/cycle_sequencer.sv
// 8-phase machine-cycle sequencer: latches OPR/OPA, tracks two-word
// instructions, issues PC/complete strobes, halts at instruction boundaries.
module cycle_sequencer #(
  parameter bit TWO_WORD_EN = 1'b1,
  parameter int M1_CYCLE    = 3,
  parameter int M2_CYCLE    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  cycle_sequencer_if.master  bus
);

  typedef enum logic {
    RUN  = 1'b0,
    STOP = 1'b1
  } state_e;

  localparam logic [2:0] M1 = 3'(M1_CYCLE);
  localparam logic [2:0] M2 = 3'(M2_CYCLE);
  localparam logic [2:0] X3 = 3'd7;

  state_e     state_q, state_d;
  logic [2:0] cycle_q, cycle_d;
  logic [3:0] opr_q, opr_d;
  logic [3:0] opa_q, opa_d;
  logic [7:0] op2_q, op2_d;
  logic       word2_q, word2_d;
  logic       sync_q, sync_d;
  logic       pc_inc_q, pc_inc_d;
  logic       exec_done_q, exec_done_d;
  logic       stop_ack_q, stop_ack_d;

  logic       is2;
  logic       two_word;
  logic       last_x3;

  // JCN/FIM/JUN/JMS/ISZ; FIM and SRC share opr 2, split on opa[0].
  always_comb begin
    is2 = 1'b0;
    unique case (opr_q)
      4'h1, 4'h4, 4'h5, 4'h7: is2 = 1'b1;
      4'h2:                   is2 = ~opa_q[0];
      default:                is2 = 1'b0;
    endcase
    two_word = TWO_WORD_EN && is2;
  end

  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    opr_d       = opr_q;
    opa_d       = opa_q;
    op2_d       = op2_q;
    word2_d     = word2_q;
    sync_d      = 1'b0;
    pc_inc_d    = 1'b0;
    exec_done_d = 1'b0;
    stop_ack_d  = stop_ack_q;
    last_x3     = 1'b0;
    unique case (state_q)
      STOP: begin
        cycle_d = '0;
        if (!bus.stop_req) begin
          state_d    = RUN;
          stop_ack_d = 1'b0;
        end
      end
      RUN: begin
        cycle_d    = cycle_q + 3'd1;
        stop_ack_d = 1'b0;
        last_x3    = (cycle_q == X3) && exec_done_q;
        if (cycle_q == M1) begin
          if (word2_q) op2_d[7:4] = bus.rom_data;
          else         opr_d      = bus.rom_data;
        end
        if (cycle_q == M2) begin
          if (word2_q) op2_d[3:0] = bus.rom_data;
          else         opa_d      = bus.rom_data;
        end
        if (cycle_q == X3) begin
          word2_d = !word2_q && two_word;
        end
        // Halt only at the final word, so two-word pairs stay intact.
        if (last_x3 && bus.stop_req) begin
          state_d    = STOP;
          cycle_d    = '0;
          stop_ack_d = 1'b1;
        end else if (cycle_d == X3) begin
          sync_d      = 1'b1;
          pc_inc_d    = 1'b1;
          exec_done_d = word2_q || !two_word;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cycle_q     <= '0;
      opr_q       <= '0;
      opa_q       <= '0;
      op2_q       <= '0;
      word2_q     <= 1'b0;
      sync_q      <= 1'b0;
      pc_inc_q    <= 1'b0;
      exec_done_q <= 1'b0;
      stop_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      opr_q       <= opr_d;
      opa_q       <= opa_d;
      op2_q       <= op2_d;
      word2_q     <= word2_d;
      sync_q      <= sync_d;
      pc_inc_q    <= pc_inc_d;
      exec_done_q <= exec_done_d;
      stop_ack_q  <= stop_ack_d;
    end
  end

  assign bus.cycle     = cycle_q;
  assign bus.sync      = sync_q;
  assign bus.opr       = opr_q;
  assign bus.opa       = opa_q;
  assign bus.op2       = op2_q;
  assign bus.word2     = word2_q;
  assign bus.pc_inc    = pc_inc_q;
  assign bus.exec_done = exec_done_q;
  assign bus.stop_ack  = stop_ack_q;

endmodule
